// File: rtl/shift_chain_pkg.sv
// Shared types and constants for the shift-register chain driver.
package shift_chain_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShiftLo,
        StShiftHi,
        StLatch,
        StDone
    } state_e;

    localparam int unsigned DefNumBits    = 400;
    localparam int unsigned DefClkDiv     = 4;
    localparam int unsigned DefRefreshCyc = 1000000;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sr_tick_gen.sv
// Half-period timer for the serial clock: counts CLK_DIV cycles and pulses
// tick on the last one. Holding restart parks the counter at zero so the next
// phase starts on a clean boundary.
module sr_tick_gen
    import shift_chain_pkg::*;
#(
    parameter int unsigned CLK_DIV = DefClkDiv
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int unsigned    CntW    = cnt_width(CLK_DIV + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count and end-of-phase tick.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LastCnt) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Phase counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shift_chain_driver.sv
// Serialises the register image into a 74HC595-style chain (SER/SRCLK/RCLK/OE_n).
// A frame is sent after reset, on any image change and on force_update; the image
// is snapshotted at LOAD so later changes only queue another frame.
// Optional feature: define SHIFT_REFRESH_EN to add a periodic forced refresh every
// REFRESH_CYC clocks.
module shift_chain_driver
    import shift_chain_pkg::*;
#(
    parameter int unsigned NUM_BITS = DefNumBits,
    parameter int unsigned CLK_DIV  = DefClkDiv
`ifdef SHIFT_REFRESH_EN
    ,
    parameter int unsigned REFRESH_CYC = DefRefreshCyc
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] reg_bits,
    input  logic                force_update,
    output logic                sr_ser,
    output logic                sr_clk,
    output logic                sr_latch,
    output logic                sr_oe_n,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned        BitCntW  = cnt_width(NUM_BITS);
    localparam logic [BitCntW-1:0] FirstBit = BitCntW'(NUM_BITS - 1);

    state_e               state_q, state_d;
    logic [NUM_BITS-1:0]  snap_q, snap_d;
    logic [NUM_BITS-1:0]  shadow_q, shadow_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 pending_q, pending_d;
    logic                 tick;
    logic                 tick_restart;
    logic                 refresh_req;

    logic ser_q, ser_d;
    logic clk_q, clk_d;
    logic latch_q, latch_d;
    logic oe_n_q, oe_n_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Timer only runs through the timed states; it restarts everywhere else.
    assign tick_restart = !(state_q == StShiftLo || state_q == StShiftHi ||
                            state_q == StLatch);

    sr_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (tick_restart),
        .tick    (tick)
    );

`ifdef SHIFT_REFRESH_EN
    localparam int unsigned     RefW    = cnt_width(REFRESH_CYC);
    localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYC - 1);

    logic [RefW-1:0] ref_cnt_q;

    // Free-running scrub timer; wraps after REFRESH_CYC clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
        end else if (ref_cnt_q == RefLast) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    assign refresh_req = (ref_cnt_q == RefLast);
`else
    assign refresh_req = 1'b0;
`endif

    // Frame request tracking. In LOAD the shadow catches up with the image, so only
    // a coincident explicit request may re-arm pending there.
    always_comb begin
        if (state_q == StLoad) begin
            pending_d = force_update | refresh_req;
        end else begin
            pending_d = pending_q | (reg_bits != shadow_q) | force_update | refresh_req;
        end
    end

    // Frame sequencer next state.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pending_q) state_d = StLoad;
            end
            StLoad: begin
                snap_d    = reg_bits;
                shadow_d  = reg_bits;
                bit_cnt_d = FirstBit;
                state_d   = StShiftLo;
            end
            StShiftLo: begin
                if (tick) state_d = StShiftHi;
            end
            StShiftHi: begin
                if (tick) begin
                    if (bit_cnt_q == '0) begin
                        state_d = StLatch;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = StShiftLo;
                    end
                end
            end
            StLatch: begin
                if (tick) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so the chain pins never glitch.
    always_comb begin
        ser_d   = 1'b0;
        clk_d   = (state_d == StShiftHi);
        latch_d = (state_d == StLatch);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        oe_n_d  = oe_n_q & (state_d != StDone);
        if (state_d == StShiftLo || state_d == StShiftHi) begin
            ser_d = snap_d[bit_cnt_d];
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            snap_q    <= '0;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b1;
            ser_q     <= 1'b0;
            clk_q     <= 1'b0;
            latch_q   <= 1'b0;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            pending_q <= pending_d;
            ser_q     <= ser_d;
            clk_q     <= clk_d;
            latch_q   <= latch_d;
            oe_n_q    <= oe_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign sr_ser     = ser_q;
    assign sr_clk     = clk_q;
    assign sr_latch   = latch_q;
    assign sr_oe_n    = oe_n_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_shift_chain_driver.sv
// Bench for shift_chain_driver: models the external 400-stage chain and its
// storage register, and checks latched content, frame timing and reset behaviour.
module tb_shift_chain_driver;

    localparam int NB        = 400;
    localparam int CD        = 4;
    localparam int FRAME_LEN = 1 + 2 * CD * NB + CD + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] reg_bits = '0;
    logic          force_update = 1'b0;
    logic          sr_ser, sr_clk, sr_latch, sr_oe_n, busy, frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    shift_chain_driver #(
        .NUM_BITS    (NB),
        .CLK_DIV     (CD)
`ifdef SHIFT_REFRESH_EN
        ,
        .REFRESH_CYC (5000)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_bits     (reg_bits),
        .force_update (force_update),
        .sr_ser       (sr_ser),
        .sr_clk       (sr_clk),
        .sr_latch     (sr_latch),
        .sr_oe_n      (sr_oe_n),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Chain model plus frame monitors, sampled on the falling edge.
    logic [NB-1:0] chain = '1;
    logic [NB-1:0] store = '1;
    logic          prev_sclk = 1'b0;
    logic          prev_latch = 1'b0;
    logic          ser_at_rise = 1'b0;
    logic          first_bit = 1'b0;
    int            shift_cnt = 0;
    int            ser_viol = 0;
    int            busy_len = 0;
    int            last_len = 0;
    int            frame_count = 0;
    int            cyc = 0;
    int            last_done_cyc = 0;
    int            last_gap = 0;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_sclk  <= sr_clk;
        prev_latch <= sr_latch;
        if (sr_clk && !prev_sclk) begin
            chain       <= {chain[NB-2:0], sr_ser};
            ser_at_rise <= sr_ser;
            if (shift_cnt == 0) first_bit <= sr_ser;
            shift_cnt <= shift_cnt + 1;
        end else if (!busy) begin
            shift_cnt <= 0;
        end
        if (sr_clk && prev_sclk && (sr_ser !== ser_at_rise)) ser_viol <= ser_viol + 1;
        if (sr_latch && !prev_latch) store <= chain;
        busy_len <= busy ? busy_len + 1 : 0;
        if (frame_done) begin
            frame_count   <= frame_count + 1;
            last_len      <= busy_len + 1;
            last_gap      <= cyc - last_done_cyc;
            last_done_cyc <= cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (frame_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_force();
        force_update = 1'b1;
        step(1);
        force_update = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        step(3);
        n_cmp++;
        if ({sr_ser, sr_clk, sr_latch, busy, frame_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 00000",
                     {sr_ser, sr_clk, sr_latch, busy, frame_done});
        end
        n_cmp++;
        if (sr_oe_n !== 1'b1) begin
            n_bad++; $display("FAIL reset_oe_n: got %b want 1", sr_oe_n);
        end
        rst_n = 1'b1;
        step(1);
        n_cmp++;
        if (busy !== 1'b1 || sr_oe_n !== 1'b1) begin
            n_bad++; $display("FAIL first_load: busy=%b oe_n=%b want busy=1 oe_n=1", busy, sr_oe_n);
        end
        wait_frames(1, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL reset_frame_timeout: no frame_done in 4000 cycles"); end
        n_cmp++;
        if (last_len !== FRAME_LEN) begin
            n_bad++; $display("FAIL frame_len: got %0d want %0d", last_len, FRAME_LEN);
        end
        n_cmp++;
        if (sr_oe_n !== 1'b0) begin n_bad++; $display("FAIL oe_after_frame: got %b want 0", sr_oe_n); end
        n_cmp++;
        if (store !== '0) begin n_bad++; $display("FAIL zero_image: got %h want 0", store); end
    endtask

    task automatic test_corner_bits();
        bit            ok;
        int            fc;
        logic [NB-1:0] exp;
        exp      = '0;
        exp[0]   = 1'b1;
        exp[NB-1] = 1'b1;
        fc       = frame_count;
        step(5);
        reg_bits = exp;
        step(1);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL load_early: busy got %b want 0", busy); end
        step(1);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL load_latency: busy got %b want 1", busy); end
        wait_frames(fc + 1, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL corner_timeout: no frame_done"); end
        n_cmp++;
        if (store !== exp) begin n_bad++; $display("FAIL corner_image: got %h want %h", store, exp); end
        n_cmp++;
        if (first_bit !== 1'b1) begin n_bad++; $display("FAIL first_ser: got %b want 1", first_bit); end
        n_cmp++;
        if (last_len !== FRAME_LEN) begin
            n_bad++; $display("FAIL corner_len: got %0d want %0d", last_len, FRAME_LEN);
        end
    endtask

    task automatic test_mid_frame_change();
        bit            ok;
        int            fc;
        logic [NB-1:0] old_img, new_img;
        old_img    = reg_bits;
        new_img    = reg_bits;
        new_img[5] = 1'b1;
        fc         = frame_count;
        pulse_force();
        step(100);
        reg_bits = new_img;
        wait_frames(fc + 1, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mid_timeout1: no frame_done"); end
        n_cmp++;
        if (store !== old_img) begin
            n_bad++; $display("FAIL snapshot_image: got %h want %h", store, old_img);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL gap_idle: busy got %b want 0", busy); end
        step(1);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL requeue_load: busy got %b want 1", busy); end
        wait_frames(fc + 2, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL mid_timeout2: no second frame_done"); end
        n_cmp++;
        if (store !== new_img) begin
            n_bad++; $display("FAIL requeue_image: got %h want %h", store, new_img);
        end
    endtask

    task automatic test_force_update();
        bit            ok;
        int            fc;
        logic [NB-1:0] exp;
        exp = reg_bits;
        step(20);
        fc = frame_count;
        pulse_force();
        wait_frames(fc + 1, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL force_timeout: no frame_done"); end
        n_cmp++;
        if (store !== exp) begin n_bad++; $display("FAIL force_image: got %h want %h", store, exp); end
        step(10000);
`ifndef SHIFT_REFRESH_EN
        n_cmp++;
        if (frame_count !== fc + 1) begin
            n_bad++; $display("FAIL spurious_frame: frames got %0d want %0d", frame_count, fc + 1);
        end
`endif
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int fc;
        pulse_force();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sr_clk === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL shift_hi_timeout: sr_clk never high"); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sr_clk, sr_latch, sr_oe_n, busy} !== 4'b0010) begin
            n_bad++;
            $display("FAIL async_reset: clk,latch,oe_n,busy got %b want 0010",
                     {sr_clk, sr_latch, sr_oe_n, busy});
        end
        reg_bits = '0;
        step(2);
        rst_n = 1'b1;
        fc    = frame_count;
        wait_frames(fc + 1, 4000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rst_frame_timeout: no frame_done"); end
        n_cmp++;
        if (store !== '0 || sr_oe_n !== 1'b0) begin
            n_bad++; $display("FAIL rst_frame: oe_n=%b image=%h want 0/0", sr_oe_n, store);
        end
        n_cmp++;
        if (ser_viol !== 0) begin
            n_bad++; $display("FAIL ser_stability: got %0d changes want 0", ser_viol);
        end
    endtask

`ifdef SHIFT_REFRESH_EN
    task automatic test_refresh();
        bit ok;
        int fc;
        fc = frame_count;
        wait_frames(fc + 3, 16000, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL refresh_timeout: too few frames"); end
        n_cmp++;
        if (last_gap !== 5000) begin n_bad++; $display("FAIL refresh_gap: got %0d want 5000", last_gap); end
    endtask
`endif

    initial begin
        test_reset();
        test_corner_bits();
        test_mid_frame_change();
        test_force_update();
        test_reset_mid_frame();
`ifdef SHIFT_REFRESH_EN
        test_refresh();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
